// File: rtl/output_peripheral_pkg.sv
// Shared address map, LCD register layout and strobe FSM state type
// for the memory-mapped output peripheral.
package output_peripheral_pkg;

  localparam logic [11:0] ADDR_LEDR   = 12'h700;
  localparam logic [11:0] ADDR_LEDG   = 12'h710;
  localparam logic [11:0] ADDR_HEX_LO = 12'h720;
  localparam logic [11:0] ADDR_HEX_HI = 12'h730;
  localparam logic [11:0] ADDR_LCD    = 12'h7A0;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lcd_state_e;

  localparam int LCD_RS_BIT   = 8;
  localparam int LCD_RW_BIT   = 9;
  localparam int LCD_ON_BIT   = 10;
  localparam int LCD_OVR_BIT  = 30;
  localparam int LCD_BUSY_BIT = 31;

  // Writable part of the LCD register: data[7:0], rs, rw, on.
  localparam int LCD_REG_W = LCD_ON_BIT + 1;

endpackage

// File: rtl/output_peripheral_lcd_strobe_fsm.sv
// Timed LCD E-strobe sequencer: SETUP (E low), PULSE (E high), HOLD (E low),
// with busy asserted for the whole sequence.
module lcd_strobe_fsm
  import output_peripheral_pkg::*;
#(
  parameter int LCD_SETUP_CYC = 2,
  parameter int LCD_PULSE_CYC = 12,
  parameter int LCD_HOLD_CYC  = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic busy_o,
  output logic en_o
);

  localparam int MAX_SP  = (LCD_SETUP_CYC > LCD_PULSE_CYC) ? LCD_SETUP_CYC : LCD_PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > LCD_HOLD_CYC) ? MAX_SP : LCD_HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(LCD_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(LCD_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(LCD_HOLD_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    busy_d = (state_d != IDLE);
    en_d   = (state_d == PULSE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign busy_o = busy_q;
  assign en_o   = en_q;

endmodule

// File: rtl/output_peripheral.sv
// Store-path output peripheral: LED, seven-segment and LCD registers with
// byte-lane writes, combinational readback and a timed LCD strobe.
module output_peripheral
  import output_peripheral_pkg::*;
#(
  parameter int LCD_SETUP_CYC = 2,
  parameter int LCD_PULSE_CYC = 12,
  parameter int LCD_HOLD_CYC  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] addr_i,
  input  logic        st_en_i,
  input  logic [31:0] st_data_i,
  input  logic [3:0]  bmask_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] io_ledr_o,
  output logic [31:0] io_ledg_o,
  output logic [55:0] io_hex_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_on_o,
  output logic        lcd_en_o
);

  logic [31:0]          ledr_q, ledr_d;
  logic [31:0]          ledg_q, ledg_d;
  logic [31:0]          hex_lo_q, hex_lo_d;
  logic [31:0]          hex_hi_q, hex_hi_d;
  logic [LCD_REG_W-1:0] lcd_q, lcd_d;
  logic                 ovr_q, ovr_d;
  logic                 lcd_busy;
  logic                 lcd_start;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    hex_lo_d  = hex_lo_q;
    hex_hi_d  = hex_hi_q;
    lcd_d     = lcd_q;
    ovr_d     = ovr_q;
    lcd_start = 1'b0;
    if (st_en_i) begin
      case (addr_i)
        ADDR_LEDR:   ledr_d   = merge_lanes(ledr_q, st_data_i, bmask_i);
        ADDR_LEDG:   ledg_d   = merge_lanes(ledg_q, st_data_i, bmask_i);
        ADDR_HEX_LO: hex_lo_d = merge_lanes(hex_lo_q, st_data_i, bmask_i);
        ADDR_HEX_HI: hex_hi_d = merge_lanes(hex_hi_q, st_data_i, bmask_i);
        ADDR_LCD: begin
          // A refused store changes nothing but the sticky overrun flag.
          if (lcd_busy) begin
            ovr_d = 1'b1;
          end else begin
            lcd_start = 1'b1;
            ovr_d     = 1'b0;
            if (bmask_i[0]) lcd_d[7:0] = st_data_i[7:0];
            if (bmask_i[1]) lcd_d[LCD_ON_BIT:LCD_RS_BIT] = st_data_i[LCD_ON_BIT:LCD_RS_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hex_lo_q <= '0;
      hex_hi_q <= '0;
      lcd_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      hex_lo_q <= hex_lo_d;
      hex_hi_q <= hex_hi_d;
      lcd_q    <= lcd_d;
      ovr_q    <= ovr_d;
    end
  end

  lcd_strobe_fsm #(
    .LCD_SETUP_CYC (LCD_SETUP_CYC),
    .LCD_PULSE_CYC (LCD_PULSE_CYC),
    .LCD_HOLD_CYC  (LCD_HOLD_CYC)
  ) u_lcd_strobe_fsm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (lcd_start),
    .busy_o  (lcd_busy),
    .en_o    (lcd_en_o)
  );

  always_comb begin
    ld_data_o = '0;
    case (addr_i)
      ADDR_LEDR:   ld_data_o = ledr_q;
      ADDR_LEDG:   ld_data_o = ledg_q;
      ADDR_HEX_LO: ld_data_o = hex_lo_q;
      ADDR_HEX_HI: ld_data_o = hex_hi_q;
      ADDR_LCD: begin
        ld_data_o[LCD_REG_W-1:0] = lcd_q;
        ld_data_o[LCD_OVR_BIT]   = ovr_q;
        ld_data_o[LCD_BUSY_BIT]  = lcd_busy;
      end
      default: ;
    endcase
  end

  // Segment bit 7 of every HEX byte is storage only.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      io_hex_o[7*k +: 7]      = hex_lo_q[8*k +: 7];
      io_hex_o[28 + 7*k +: 7] = hex_hi_q[8*k +: 7];
    end
  end

  assign io_ledr_o  = ledr_q;
  assign io_ledg_o  = ledg_q;
  assign lcd_data_o = lcd_q[7:0];
  assign lcd_rs_o   = lcd_q[LCD_RS_BIT];
  assign lcd_rw_o   = lcd_q[LCD_RW_BIT];
  assign lcd_on_o   = lcd_q[LCD_ON_BIT];

endmodule

// File: tb/tb_output_peripheral.sv
// Scoreboard bench for output_peripheral: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_output_peripheral;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [11:0] addr_i;
  logic        st_en_i;
  logic [31:0] st_data_i;
  logic [3:0]  bmask_i;
  logic [31:0] ld_data_o;
  logic [31:0] io_ledr_o;
  logic [31:0] io_ledg_o;
  logic [55:0] io_hex_o;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o, lcd_rw_o, lcd_on_o, lcd_en_o;

  output_peripheral dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .addr_i     (addr_i),
    .st_en_i    (st_en_i),
    .st_data_i  (st_data_i),
    .bmask_i    (bmask_i),
    .ld_data_o  (ld_data_o),
    .io_ledr_o  (io_ledr_o),
    .io_ledg_o  (io_ledg_o),
    .io_hex_o   (io_hex_o),
    .lcd_data_o (lcd_data_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_on_o   (lcd_on_o),
    .lcd_en_o   (lcd_en_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int S_LD = 0, S_LEDR = 1, S_LEDG = 2, S_HEX = 3, S_LDATA = 4,
                 S_RS = 5, S_RW = 6, S_ON = 7, S_EN = 8;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_LD:    return {32'b0, ld_data_o};
      S_LEDR:  return {32'b0, io_ledr_o};
      S_LEDG:  return {32'b0, io_ledg_o};
      S_HEX:   return {8'b0, io_hex_o};
      S_LDATA: return {56'b0, lcd_data_o};
      S_RS:    return {63'b0, lcd_rs_o};
      S_RW:    return {63'b0, lcd_rw_o};
      S_ON:    return {63'b0, lcd_on_o};
      S_EN:    return {63'b0, lcd_en_o};
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // Monitor: compare every expectation tagged with the current cycle.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [63:0] got;
        got = observe(sb[i].sel);
        checks++;
        if (got !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [63:0] e, input string n);
    exp_t t;
    t.cyc = c; t.sel = sel; t.exp = e; t.name = n;
    sb.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [11:0] map_addrs [5] = '{12'h700, 12'h710, 12'h720, 12'h730, 12'h7A0};

  initial begin
    int          t0;
    logic [31:0] e_ld;
    rst_ni = 1'b0; st_en_i = 1'b0; addr_i = '0; st_data_i = '0; bmask_i = '0;
    repeat (3) tick();
    rst_ni = 1'b1;

    // Reset state: pins and every readback are zero.
    expect_at(cyc, S_LEDR, 0, "rst_ledr");
    expect_at(cyc, S_LEDG, 0, "rst_ledg");
    expect_at(cyc, S_HEX, 0, "rst_hex");
    expect_at(cyc, S_LDATA, 0, "rst_lcd_data");
    expect_at(cyc, S_ON, 0, "rst_lcd_on");
    expect_at(cyc, S_EN, 0, "rst_lcd_en");
    for (int i = 0; i < 5; i++) begin
      addr_i = map_addrs[i];
      expect_at(cyc, S_LD, 0, "rst_rd");
      tick();
    end

    // LEDR byte-lane write over a full-word preload.
    addr_i = 12'h700; st_data_i = 32'h1111_1111; bmask_i = 4'hF; st_en_i = 1'b1;
    tick();
    st_data_i = 32'hDEAD_BEEF; bmask_i = 4'b0101;
    expect_at(cyc, S_LEDR, 32'h1111_1111, "ledr_preload");
    expect_at(cyc, S_LD, 32'h1111_1111, "ledr_rd_old");
    tick();
    st_en_i = 1'b0;
    checks++;
    if (io_ledr_o !== 32'h11AD_11EF) begin
      errors++;
      $display("FAIL ledr_pin_direct got=%h", io_ledr_o);
    end
    expect_at(cyc, S_LEDR, 32'h11AD_11EF, "ledr_pin");
    expect_at(cyc, S_LD, 32'h11AD_11EF, "ledr_rd");
    tick();
    st_en_i = 1'b1; st_data_i = 32'h0; bmask_i = 4'b0000;
    tick();
    st_en_i = 1'b0;
    expect_at(cyc, S_LEDR, 32'h11AD_11EF, "ledr_bmask0");
    tick();

    // LEDG single-lane write.
    addr_i = 12'h710; st_data_i = 32'hCCCC_CCA5; bmask_i = 4'b0001; st_en_i = 1'b1;
    tick();
    st_en_i = 1'b0;
    expect_at(cyc, S_LEDG, 32'h0000_00A5, "ledg_pin");
    expect_at(cyc, S_LD, 32'h0000_00A5, "ledg_rd");
    tick();

    // HEX registers: same-cycle load sees old value, bit 7 stored but not driven.
    addr_i = 12'h720; st_data_i = 32'h8C2B_0A01; bmask_i = 4'hF; st_en_i = 1'b1;
    tick();
    addr_i = 12'h730; st_data_i = 32'h0000_1234;
    tick();
    st_data_i = 32'h7F3F_067B;
    expect_at(cyc, S_LD, 32'h0000_1234, "hex_same_cyc_rd");
    tick();
    st_en_i = 1'b0;
    checks++;
    if (io_hex_o !== {7'h7F, 7'h3F, 7'h06, 7'h7B, 7'h0C, 7'h2B, 7'h0A, 7'h01}) begin
      errors++;
      $display("FAIL hex_pins_direct got=%h", io_hex_o);
    end
    expect_at(cyc, S_HEX, {7'h7F, 7'h3F, 7'h06, 7'h7B, 7'h0C, 7'h2B, 7'h0A, 7'h01}, "hex_pins");
    expect_at(cyc, S_LD, 32'h7F3F_067B, "hex_hi_rd");
    tick();
    addr_i = 12'h720;
    expect_at(cyc, S_LD, 32'h8C2B_0A01, "hex_lo_bit7_rd");
    tick();

    // Unmapped addresses: read 0, stores ignored.
    addr_i = 12'h740; st_data_i = 32'hFFFF_FFFF; bmask_i = 4'hF; st_en_i = 1'b1;
    expect_at(cyc, S_LD, 0, "unmap_rd");
    tick();
    st_en_i = 1'b0; addr_i = 12'h704;
    expect_at(cyc, S_LD, 0, "unmap_rd2");
    expect_at(cyc, S_LEDR, 32'h11AD_11EF, "unmap_ledr_kept");
    expect_at(cyc, S_LEDG, 32'h0000_00A5, "unmap_ledg_kept");
    tick();

    // LCD sequence: accepted at t0, refused at t0+5, next accepted at t0+17.
    addr_i = 12'h7A0; st_data_i = 32'h0000_0541; bmask_i = 4'hF; st_en_i = 1'b1;
    t0 = cyc;
    expect_at(cyc, S_LD, 0, "lcd_rd_pre");
    tick();
    st_en_i = 1'b0;
    checks++;
    if (lcd_data_o !== 8'h41) begin
      errors++;
      $display("FAIL lcd_data_direct got=%h", lcd_data_o);
    end
    checks++;
    if (lcd_on_o !== 1'b1) begin
      errors++;
      $display("FAIL lcd_on_direct got=%b", lcd_on_o);
    end
    expect_at(cyc, S_LDATA, 8'h41, "lcd_data");
    expect_at(cyc, S_RS, 1, "lcd_rs");
    expect_at(cyc, S_RW, 0, "lcd_rw");
    expect_at(cyc, S_ON, 1, "lcd_on");
    for (int k = 1; k <= 18; k++) begin
      if (k == 5) begin
        st_en_i = 1'b1; st_data_i = 32'h0; bmask_i = 4'hF;
      end
      if (k == 17) begin
        st_en_i = 1'b1; st_data_i = 32'h0000_0652; bmask_i = 4'b0011;
      end
      if (k <= 17) e_ld = 32'h0000_0541;
      else         e_ld = 32'h0000_0652;
      if (k <= 16 || k == 18) e_ld[31] = 1'b1;
      if (k >= 6 && k <= 17)  e_ld[30] = 1'b1;
      expect_at(cyc, S_LD, {32'b0, e_ld}, "lcd_rd_seq");
      expect_at(cyc, S_EN, {63'b0, (k >= 3 && k <= 14)}, "lcd_en_seq");
      expect_at(cyc, S_LDATA, (k <= 17) ? 8'h41 : 8'h52, "lcd_data_hold");
      tick();
      st_en_i = 1'b0;
    end
    expect_at(cyc, S_RW, 1, "lcd_rw2");

    // Reset in the middle of the second pulse (t0+20..t0+31).
    while (cyc < t0 + 24) tick();
    expect_at(cyc, S_EN, 1, "en_before_rst");
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checks++;
    if (lcd_en_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_en_direct got=%b", lcd_en_o);
    end
    st_en_i = 1'b1; st_data_i = 32'h0000_04FF; bmask_i = 4'hF;
    expect_at(cyc, S_EN, 0, "rst_mid_en");
    expect_at(cyc, S_LD, 0, "rst_mid_rd");
    expect_at(cyc, S_LDATA, 0, "rst_mid_lcd_data");
    expect_at(cyc, S_ON, 0, "rst_mid_lcd_on");
    expect_at(cyc, S_LEDR, 0, "rst_mid_ledr");
    expect_at(cyc, S_HEX, 0, "rst_mid_hex");
    tick();
    st_en_i = 1'b0;
    expect_at(cyc, S_LD, 32'h8000_04FF, "post_rst_accept");
    expect_at(cyc, S_LDATA, 8'hFF, "post_rst_data");
    expect_at(cyc, S_EN, 0, "post_rst_en_setup");
    tick();
    tick();
    expect_at(cyc, S_EN, 1, "post_rst_en_pulse");
    repeat (20) tick();
    @(negedge clk_i);
    #1;

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s unchecked cyc=%0d", sb[i].name, sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
